prpg_lfsr_gen: RTL and testbench

//  Parametrised pseudo-random pattern generator and signature compactor.

---
 rtl/prpg_lfsr_gen.sv | 102 ++++++++++
 tb/tb_prpg_lfsr_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/prpg_lfsr_gen.sv
// Fibonacci LFSR pattern generator / MISR signature compactor with
// programmable taps, run-time seed load, lock-up recovery and period measurement.
module prpg_lfsr_gen #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic             wrap,
  output logic             lockup,
  output logic [WIDTH-1:0] period
);

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] start_r;
  logic [WIDTH-1:0] cnt_r;
  logic             fb_s;
  logic [WIDTH-1:0] nxt_s;
  logic [WIDTH-1:0] cnt_inc_s;

  function automatic logic parity_f(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  // Next-state feedback and saturating step counter increment
  always_comb begin
    fb_s  = parity_f(out & POLY);
    nxt_s = {out[WIDTH-2:0], fb_s};
    if (mode) begin
      nxt_s = nxt_s ^ din;
    end else begin
      nxt_s = nxt_s;
    end
    if (cnt_r == ONES_W) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + ONE_W;
    end
  end

  // State register: load has priority over step, otherwise hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out     <= SEED;
      start_r <= SEED;
      cnt_r   <= ZERO_W;
      period  <= ZERO_W;
      valid   <= 1'b0;
      wrap    <= 1'b0;
      lockup  <= 1'b0;
    end else if (load) begin
      out     <= seed_in;
      start_r <= seed_in;
      cnt_r   <= ZERO_W;
      valid   <= 1'b0;
      wrap    <= 1'b0;
      lockup  <= 1'b0;
    end else if (en) begin
      valid <= 1'b1;
      if (mode) begin
        // Compression: zero state is legal, no wrap tracking
        out    <= nxt_s;
        cnt_r  <= cnt_inc_s;
        wrap   <= 1'b0;
        lockup <= 1'b0;
      end else if (out == ZERO_W) begin
        out     <= SEED;
        start_r <= SEED;
        cnt_r   <= ZERO_W;
        wrap    <= 1'b0;
        lockup  <= 1'b1;
      end else begin
        out    <= nxt_s;
        lockup <= 1'b0;
        if (nxt_s == start_r) begin
          wrap   <= 1'b1;
          period <= cnt_inc_s;
          cnt_r  <= ZERO_W;
        end else begin
          wrap  <= 1'b0;
          cnt_r <= cnt_inc_s;
        end
      end
    end else begin
      valid  <= 1'b0;
      wrap   <= 1'b0;
      lockup <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prpg_lfsr_gen.sv
// Self-checking bench: cycle model of the default 8-bit generator plus
// directed literal checks, including a 3-bit instance.
module tb_prpg_lfsr_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, load, mode;
  logic [7:0] seed_in, din;
  logic [7:0] out, period;
  logic       valid, wrap, lockup;

  logic       en3;
  logic [2:0] out3, period3;
  logic       valid3, wrap3, lockup3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prpg_lfsr_gen dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .mode(mode),
    .seed_in(seed_in), .din(din), .out(out), .valid(valid),
    .wrap(wrap), .lockup(lockup), .period(period)
  );

  prpg_lfsr_gen #(.WIDTH(3), .POLY(3'b101), .SEED(3'b100)) dut3 (
    .clk(clk), .rst(rst), .en(en3), .load(1'b0), .mode(1'b0),
    .seed_in(3'b000), .din(3'b000), .out(out3), .valid(valid3),
    .wrap(wrap3), .lockup(lockup3), .period(period3)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: parity of tapped bits appended to a doubled state
  function automatic logic [7:0] model_next(input logic [7:0] s, input logic m,
                                            input logic [7:0] d);
    int v;
    v = ((int'(s) * 2) % 256) + ($countones(s & 8'hB8) % 2);
    if (m) v = v ^ int'(d);
    return v[7:0];
  endfunction

  logic [7:0] m_out, m_start, m_cnt, m_period;
  logic       m_valid, m_wrap, m_lock;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_out <= 8'h01; m_start <= 8'h01; m_cnt <= 8'd0; m_period <= 8'd0;
      m_valid <= 1'b0; m_wrap <= 1'b0; m_lock <= 1'b0;
    end else if (load) begin
      m_out <= seed_in; m_start <= seed_in; m_cnt <= 8'd0;
      m_valid <= 1'b0; m_wrap <= 1'b0; m_lock <= 1'b0;
    end else if (en) begin
      m_valid <= 1'b1;
      if (!mode && m_out == 8'h00) begin
        m_out <= 8'h01; m_start <= 8'h01; m_cnt <= 8'd0;
        m_lock <= 1'b1; m_wrap <= 1'b0;
      end else begin
        m_out  <= model_next(m_out, mode, din);
        m_lock <= 1'b0;
        if (!mode && model_next(m_out, mode, din) == m_start) begin
          m_wrap <= 1'b1; m_period <= m_cnt + 8'd1; m_cnt <= 8'd0;
        end else begin
          m_wrap <= 1'b0;
          m_cnt  <= (m_cnt == 8'd255) ? m_cnt : m_cnt + 8'd1;
        end
      end
    end else begin
      m_valid <= 1'b0; m_wrap <= 1'b0; m_lock <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("model_out", out, m_out);
    chk("model_valid", valid, m_valid);
    chk("model_wrap", wrap, m_wrap);
    chk("model_lockup", lockup, m_lock);
    chk("model_period", period, m_period);
  end

  bit   seen [256];
  int   wraps;
  logic [2:0] exp3 [7];

  initial begin
    exp3 = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b101, 3'b010, 3'b100};
    rst = 1'b0; en = 1'b0; load = 1'b0; mode = 1'b0;
    seed_in = 8'h00; din = 8'h00; en3 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out", out, 8'h01);
    chk("rst_valid", valid, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_lockup", lockup, 0);
    chk("rst_period", period, 0);
    rst = 1'b1;
    @(negedge clk);

    // Full maximal-length cycle
    foreach (seen[i]) seen[i] = 1'b0;
    seen[8'h01] = 1'b1;
    wraps = 0;
    en = 1'b1;
    for (int k = 1; k <= 255; k++) begin
      @(negedge clk);
      if (wrap) wraps++;
      if (k < 255) begin
        chk("no_repeat", int'(seen[out]), 0);
        seen[out] = 1'b1;
      end
    end
    chk("p255_wrap", wrap, 1);
    chk("p255_period", period, 255);
    chk("p255_out", out, 8'h01);
    chk("p255_wrap_count", wraps, 1);
    en = 1'b0;
    @(negedge clk);
    chk("hold_valid", valid, 0);
    chk("hold_period", period, 255);

    // Zero seed then step in generate mode triggers lock-up recovery
    load = 1'b1; seed_in = 8'h00;
    @(negedge clk);
    chk("load0_out", out, 8'h00);
    load = 1'b0; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk("lock_out", out, 8'h01);
    chk("lock_lockup", lockup, 1);
    chk("lock_valid", valid, 1);
    chk("lock_wrap", wrap, 0);

    // MISR compression from zero
    mode = 1'b1; load = 1'b1; seed_in = 8'h00;
    @(negedge clk);
    load = 1'b0; en = 1'b1; din = 8'h01;
    @(negedge clk);
    chk("misr1_out", out, 8'h01);
    chk("misr1_flags", {wrap, lockup}, 0);
    din = 8'h00;
    @(negedge clk);
    chk("misr2_out", out, 8'h02);
    chk("misr2_flags", {wrap, lockup}, 0);
    en = 1'b0; mode = 1'b0;

    // load beats en; then asynchronous reset between edges
    load = 1'b1; en = 1'b1; seed_in = 8'h5A;
    @(negedge clk);
    chk("loaden_out", out, 8'h5A);
    chk("loaden_valid", valid, 0);
    load = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1 chk("async_rst_out", out, 8'h01);
    chk("async_rst_period", period, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_step", out, 8'h02);
    en = 1'b0;

    // 3-bit instance full cycle
    @(negedge clk);
    en3 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("w3_out", out3, exp3[i]);
      chk("w3_valid", valid3, 1);
      chk("w3_wrap", wrap3, (i == 6) ? 1 : 0);
      chk("w3_lockup", lockup3, 0);
    end
    chk("w3_period", period3, 7);
    en3 = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
